// File: rtl/w_stage_writeback_if.sv
// w_stage_writeback_if: M-stage capture inputs and W-stage GRF write port of the writeback stage
interface w_stage_writeback_if #(parameter int CNT_W = 32);
  logic             m_valid;
  logic [31:0]      m_pc;
  logic             m_reg_write;
  logic [4:0]       m_reg_addr;
  logic [1:0]       m_wb_src;
  logic [2:0]       m_load_type;
  logic [31:0]      m_alu_result;
  logic [31:0]      m_mem_rdata;
  logic             w_reg_write;
  logic [4:0]       w_reg_addr;
  logic [31:0]      w_write_data;
  logic [31:0]      w_pc;
  logic             w_align_err;
  logic [CNT_W-1:0] retired_count;
  modport master (
    output m_valid, m_pc, m_reg_write, m_reg_addr, m_wb_src, m_load_type, m_alu_result, m_mem_rdata,
    input  w_reg_write, w_reg_addr, w_write_data, w_pc, w_align_err, retired_count
  );
  modport slave (
    input  m_valid, m_pc, m_reg_write, m_reg_addr, m_wb_src, m_load_type, m_alu_result, m_mem_rdata,
    output w_reg_write, w_reg_addr, w_write_data, w_pc, w_align_err, retired_count
  );
endinterface

// File: rtl/w_stage_writeback.sv
// w_stage_writeback: MIPS M/W pipeline register, load alignment/extension and GRF write-port driver.
// Define WB_TRACE_EN to print a simulation trace of every GRF write.
module w_stage_writeback #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input logic clk,
  input logic reset,
  w_stage_writeback_if.slave bus
);
  logic [31:0]      pc, alu, rdata;
  logic [1:0]       src;
  logic [2:0]       ltype;
  logic             we, err;
  logic [4:0]       addr;
  logic [CNT_W-1:0] count;
  logic             m_lh, m_lb, misalign;
  logic [1:0]       off;
  logic [15:0]      half;
  logic [7:0]       byt;
  logic [31:0]      load, data;
  assign m_lh = bus.m_load_type == 3'd1 || bus.m_load_type == 3'd2;
  assign m_lb = bus.m_load_type == 3'd3 || bus.m_load_type == 3'd4;
  // Types 5-7 fall into the LW branch and need full word alignment
  assign misalign = bus.m_valid && bus.m_wb_src == 2'd1 &&
                    (m_lh ? bus.m_alu_result[0] : !m_lb && bus.m_alu_result[1:0] != 2'd0);
  always_ff @(posedge clk) begin
    if (reset || !bus.m_valid) begin
      pc    <= RESET_PC;
      alu   <= '0;
      rdata <= '0;
      src   <= '0;
      ltype <= '0;
      we    <= 1'b0;
      addr  <= '0;
      err   <= 1'b0;
    end else begin
      pc    <= bus.m_pc;
      alu   <= bus.m_alu_result;
      rdata <= bus.m_mem_rdata;
      src   <= bus.m_wb_src;
      ltype <= bus.m_load_type;
      we    <= bus.m_reg_write && !misalign && bus.m_reg_addr != 5'd0;
      addr  <= bus.m_reg_addr;
      err   <= misalign;
    end
    if (reset) count <= '0;
    else if (bus.m_valid) count <= count + CNT_W'(1);
  end
  assign off  = alu[1:0];
  assign half = off[1] ? rdata[31:16] : rdata[15:0];
  assign byt  = rdata[{off, 3'b000} +: 8];
  always_comb begin
    load = ltype == 3'd1 ? {{16{half[15]}}, half} :
           ltype == 3'd2 ? {16'h0000, half} :
           ltype == 3'd3 ? {{24{byt[7]}}, byt} :
           ltype == 3'd4 ? {24'h000000, byt} : rdata;
    data = src == 2'd0 ? alu :
           src == 2'd1 ? load :
           src == 2'd2 ? pc + 32'd8 : 32'h0;
  end
  assign bus.w_reg_write   = we;
  assign bus.w_reg_addr    = addr;
  assign bus.w_write_data  = data;
  assign bus.w_pc          = pc;
  assign bus.w_align_err   = err;
  assign bus.retired_count = count;
`ifdef WB_TRACE_EN
  always_ff @(posedge clk) if (!reset && we) $display("@%h: $%d <= %h", pc, addr, data);
`endif
endmodule

// File: tb/tb_w_stage_writeback.sv
// tb_w_stage_writeback: directed and randomized checks of the writeback stage against a reference model
module tb_w_stage_writeback;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  w_stage_writeback_if bus();
  w_stage_writeback dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0, errors = 0;
  logic        e_we, e_err, e_dk;
  logic [4:0]  e_addr;
  logic [31:0] e_data, e_pc, e_cnt;

  function automatic logic [31:0] wb_value(input logic [1:0] s, input logic [2:0] t,
                                           input logic [31:0] alu, rd, pc);
    int unsigned o, b, h;
    o = alu % 4;
    b = (rd >> (8 * o)) % 256;
    h = (o >= 2) ? rd / 65536 : rd % 65536;
    if (s == 0) return alu;
    if (s == 2) return pc + 32'd8;
    if (s == 3) return 32'd0;
    case (t)
      3'd1: return h >= 32768 ? h + 32'hFFFF_0000 : h;
      3'd2: return h;
      3'd3: return b >= 128 ? b + 32'hFFFF_FF00 : b;
      3'd4: return b;
      default: return rd;
    endcase
  endfunction

  task automatic cycle(input logic rst, v, rw, input logic [4:0] a, input logic [1:0] s,
                       input logic [2:0] t, input logic [31:0] pc, alu, rd);
    logic mis;
    reset = rst;
    bus.m_valid = v; bus.m_reg_write = rw; bus.m_reg_addr = a; bus.m_wb_src = s;
    bus.m_load_type = t; bus.m_pc = pc; bus.m_alu_result = alu; bus.m_mem_rdata = rd;
    @(posedge clk);
    if (rst) begin
      e_pc = 32'h3000; e_we = 0; e_addr = 0; e_data = 0; e_err = 0; e_cnt = 0; e_dk = 1;
    end else if (!v) begin
      e_pc = 32'h3000; e_we = 0; e_addr = 0; e_err = 0; e_dk = 0;
    end else begin
      if (s != 1) mis = 0;
      else if (t == 1 || t == 2) mis = alu % 2 != 0;
      else if (t == 3 || t == 4) mis = 0;
      else mis = alu % 4 != 0;
      e_err = mis; e_we = rw && !mis && a != 0; e_addr = a; e_pc = pc;
      e_data = wb_value(s, t, alu, rd, pc); e_dk = 1; e_cnt = e_cnt + 1;
    end
    #1;
  endtask

  task automatic test_reset;
    cycle(1, 1, 1, 5'd3, 2'd0, 3'd0, 32'h1, 32'h2, 32'h3);
    cycle(1, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    checks++; if (bus.w_pc !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.w_pc, 32'h3000); end
    checks++; if (bus.w_reg_write !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.w_reg_write); end
    checks++; if (bus.w_write_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.w_write_data); end
    checks++; if (bus.retired_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.retired_count); end
    checks++; if (bus.w_align_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.w_align_err); end
  endtask

  task automatic test_alu;
    cycle(0, 1, 1, 5'd5, 2'd0, 3'd0, 32'h3004, 32'h1234_5678, 32'h0);
    checks++; if ({bus.w_reg_write, bus.w_reg_addr} !== {1'b1, 5'd5}) begin errors++; $display("FAIL alu_port: got we=%b addr=%0d expected we=1 addr=5", bus.w_reg_write, bus.w_reg_addr); end
    checks++; if (bus.w_write_data !== 32'h1234_5678) begin errors++; $display("FAIL alu_data: got %h expected 12345678", bus.w_write_data); end
    checks++; if (bus.retired_count !== 32'd1) begin errors++; $display("FAIL alu_count: got %0d expected 1", bus.retired_count); end
  endtask

  task automatic test_loads;
    cycle(0, 1, 1, 5'd7, 2'd1, 3'd3, 32'h3008, 32'h0000_1003, 32'h80FF_0011);
    checks++; if ({bus.w_reg_write, bus.w_align_err, bus.w_write_data} !== {2'b10, 32'hFFFF_FF80}) begin errors++; $display("FAIL lb: got we=%b err=%b %h expected we=1 err=0 ffffff80", bus.w_reg_write, bus.w_align_err, bus.w_write_data); end
    cycle(0, 1, 1, 5'd7, 2'd1, 3'd4, 32'h300C, 32'h0000_1003, 32'h80FF_0011);
    checks++; if (bus.w_write_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu: got %h expected 00000080", bus.w_write_data); end
    cycle(0, 1, 1, 5'd8, 2'd1, 3'd1, 32'h3010, 32'h0000_1002, 32'h80FF_0011);
    checks++; if ({bus.w_reg_write, bus.w_write_data} !== {1'b1, 32'hFFFF_80FF}) begin errors++; $display("FAIL lh: got we=%b %h expected we=1 ffff80ff", bus.w_reg_write, bus.w_write_data); end
    cycle(0, 1, 1, 5'd8, 2'd1, 3'd2, 32'h3014, 32'h0000_1002, 32'h80FF_0011);
    checks++; if (bus.w_write_data !== 32'h0000_80FF) begin errors++; $display("FAIL lhu: got %h expected 000080ff", bus.w_write_data); end
  endtask

  task automatic test_align;
    logic [31:0] c0;
    c0 = bus.retired_count;
    cycle(0, 1, 1, 5'd9, 2'd1, 3'd0, 32'h3018, 32'h0000_0006, 32'hDEAD_BEEF);
    checks++; if ({bus.w_align_err, bus.w_reg_write} !== 2'b10) begin errors++; $display("FAIL lw_misalign: got err=%b we=%b expected err=1 we=0", bus.w_align_err, bus.w_reg_write); end
    checks++; if (bus.retired_count !== c0 + 1) begin errors++; $display("FAIL misalign_count: got %0d expected %0d", bus.retired_count, c0 + 1); end
    cycle(0, 1, 1, 5'd9, 2'd0, 3'd0, 32'h301C, 32'h0000_0042, 32'h0);
    checks++; if ({bus.w_align_err, bus.w_reg_write} !== 2'b01) begin errors++; $display("FAIL err_clear: got err=%b we=%b expected err=0 we=1", bus.w_align_err, bus.w_reg_write); end
  endtask

  task automatic test_link;
    cycle(0, 1, 1, 5'd31, 2'd2, 3'd0, 32'h0000_3010, 32'h0, 32'h0);
    checks++; if ({bus.w_reg_write, bus.w_reg_addr, bus.w_write_data} !== {1'b1, 5'd31, 32'h0000_3018}) begin errors++; $display("FAIL link31: got we=%b addr=%0d %h expected we=1 addr=31 00003018", bus.w_reg_write, bus.w_reg_addr, bus.w_write_data); end
    cycle(0, 1, 1, 5'd0, 2'd2, 3'd0, 32'h0000_3010, 32'h0, 32'h0);
    checks++; if ({bus.w_reg_write, bus.w_write_data} !== {1'b0, 32'h0000_3018}) begin errors++; $display("FAIL link0: got we=%b %h expected we=0 00003018", bus.w_reg_write, bus.w_write_data); end
  endtask

  task automatic test_bubble_reset;
    logic [31:0] c0;
    c0 = bus.retired_count;
    cycle(0, 0, 1, 5'd4, 2'd0, 3'd0, 32'h4000, 32'h5, 32'h0);
    checks++; if ({bus.retired_count, bus.w_reg_write, bus.w_reg_addr, bus.w_pc} !== {c0, 1'b0, 5'd0, 32'h3000}) begin errors++; $display("FAIL bubble: got cnt=%0d we=%b addr=%0d pc=%h expected cnt=%0d we=0 addr=0 pc=3000", bus.retired_count, bus.w_reg_write, bus.w_reg_addr, bus.w_pc, c0); end
    cycle(1, 1, 1, 5'd4, 2'd0, 3'd0, 32'h4000, 32'h5, 32'h0);
    checks++; if ({bus.retired_count, bus.w_reg_write, bus.w_pc} !== {32'd0, 1'b0, 32'h3000}) begin errors++; $display("FAIL reset_mid: got cnt=%0d we=%b pc=%h expected cnt=0 we=0 pc=3000", bus.retired_count, bus.w_reg_write, bus.w_pc); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      cycle(0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      checks++; if ({bus.w_reg_write, bus.w_reg_addr, bus.w_pc, bus.w_align_err, bus.retired_count} !== {e_we, e_addr, e_pc, e_err, e_cnt}) begin
        errors++; $display("FAIL rand_ctl[%0d]: got we=%b addr=%0d pc=%h err=%b cnt=%0d expected we=%b addr=%0d pc=%h err=%b cnt=%0d", i, bus.w_reg_write, bus.w_reg_addr, bus.w_pc, bus.w_align_err, bus.retired_count, e_we, e_addr, e_pc, e_err, e_cnt);
      end
      if (e_dk) begin
        checks++; if (bus.w_write_data !== e_data) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, bus.w_write_data, e_data); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_align();
    test_link();
    test_bubble_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
